// File: rtl/i2s_frame_ctrl.sv
// I2S frame controller: word-select generation, frame-boundary capture of the
// received pair, valid/ready hand-off to the effect core and transmit reload.
module i2s_frame_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             sclk,
  input  logic             rst,
  output logic             ws_gen,
  output logic             frame_start,
  input  logic [WIDTH-1:0] rx_left,
  input  logic [WIDTH-1:0] rx_right,
  output logic [WIDTH-1:0] in_left,
  output logic [WIDTH-1:0] in_right,
  output logic             in_valid,
  input  logic             in_ready,
  input  logic [WIDTH-1:0] out_left,
  input  logic [WIDTH-1:0] out_right,
  input  logic             out_valid,
  output logic             out_ready,
  output logic [WIDTH-1:0] tx_left,
  output logic [WIDTH-1:0] tx_right,
  input  logic             err_clr,
  output logic             overrun,
  output logic             underrun,
  output logic [7:0]       drop_count
);
  localparam int FRAME = 2 * WIDTH;
  localparam int CW    = $clog2(FRAME);
  localparam logic [CW-1:0] LAST  = CW'(FRAME - 1);
  localparam logic [CW-1:0] WS_LO = CW'(WIDTH - 1);
  localparam logic [CW-1:0] WS_HI = CW'(FRAME - 2);

  logic [CW-1:0]    cnt, cnt_nxt;
  logic             primed, primed_nxt;
  logic [WIDTH-1:0] obuf_left, obuf_right;
  logic             ovr_ev, und_ev;
  logic [1:0]       ev_cnt;
  logic [8:0]       drop_sum;

  // ws_gen and frame_start are registered, so both decode the count of the
  // cycle they will be visible in.
  always_comb begin
    cnt_nxt    = (cnt == LAST) ? '0 : cnt + 1'b1;
    primed_nxt = primed | (cnt == LAST);
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      cnt         <= '0;
      primed      <= 1'b0;
      ws_gen      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      primed      <= primed_nxt;
      ws_gen      <= (cnt_nxt >= WS_LO) && (cnt_nxt <= WS_HI);
      frame_start <= primed_nxt && (cnt_nxt == '0);
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      in_valid <= 1'b0;
      in_left  <= '0;
      in_right <= '0;
    end else if (frame_start) begin
      in_left  <= rx_left;
      in_right <= rx_right;
      in_valid <= 1'b1;
    end else if (in_valid && in_ready) begin
      in_valid <= 1'b0;
    end
  end

  // out_ready doubles as the buffer-empty flag.
  always_ff @(posedge sclk) begin
    if (rst) begin
      out_ready  <= 1'b1;
      obuf_left  <= '0;
      obuf_right <= '0;
      tx_left    <= '0;
      tx_right   <= '0;
    end else if (frame_start) begin
      if (!out_ready) begin
        tx_left   <= obuf_left;
        tx_right  <= obuf_right;
        out_ready <= 1'b1;
      end else if (out_valid) begin
        tx_left  <= out_left;
        tx_right <= out_right;
      end
    end else if (out_valid && out_ready) begin
      obuf_left  <= out_left;
      obuf_right <= out_right;
      out_ready  <= 1'b0;
    end
  end

  assign ovr_ev   = frame_start & in_valid & ~in_ready;
  assign und_ev   = frame_start & out_ready & ~out_valid;
  assign ev_cnt   = {1'b0, ovr_ev} + {1'b0, und_ev};
  assign drop_sum = {1'b0, (err_clr ? 8'd0 : drop_count)} + {7'd0, ev_cnt};

  // Clear is applied first so a coincident event still lands.
  always_ff @(posedge sclk) begin
    if (rst) begin
      overrun    <= 1'b0;
      underrun   <= 1'b0;
      drop_count <= '0;
    end else begin
      overrun    <= (overrun & ~err_clr) | ovr_ev;
      underrun   <= (underrun & ~err_clr) | und_ev;
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Bench for i2s_frame_ctrl: directed scenarios plus a randomized phase, all
// compared against a time-indexed reference model of the frame protocol.
module tb_i2s_frame_ctrl;
  localparam int W = 16;
  localparam int F = 2 * W;

  logic         sclk = 1'b0;
  logic         rst = 1'b1;
  logic         ws_gen, frame_start, in_valid, out_ready, overrun, underrun;
  logic [W-1:0] rx_left = '0, rx_right = '0, in_left, in_right;
  logic [W-1:0] out_left = '0, out_right = '0, tx_left, tx_right;
  logic         in_ready = 1'b0, out_valid = 1'b0, err_clr = 1'b0;
  logic [7:0]   drop_count;

  int checks = 0;
  int errors = 0;

  always #5 sclk = ~sclk;

  i2s_frame_ctrl #(.WIDTH(W)) dut (
    .sclk(sclk), .rst(rst), .ws_gen(ws_gen), .frame_start(frame_start),
    .rx_left(rx_left), .rx_right(rx_right), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(in_ready), .out_left(out_left), .out_right(out_right),
    .out_valid(out_valid), .out_ready(out_ready), .tx_left(tx_left), .tx_right(tx_right),
    .err_clr(err_clr), .overrun(overrun), .underrun(underrun), .drop_count(drop_count)
  );

  // Reference model: m_t is the cycle index since reset release.
  int           m_t;
  logic         m_iv, m_ov, m_un;
  logic [W-1:0] m_il, m_ir, m_tl, m_tr;
  logic [2*W-1:0] m_q[$];
  int           m_dc, m_ev;
  bit           m_f;

  function automatic bit m_fs();
    return (m_t >= F) && (m_t % F == 0);
  endfunction

  function automatic logic [77:0] exp_vec();
    int c = m_t % F;
    return {1'(c >= W - 1 && c <= F - 2), m_fs(), m_iv, m_il, m_ir, 1'(m_q.size() == 0),
            m_tl, m_tr, m_ov, m_un, 8'(m_dc)};
  endfunction

  logic [77:0] act;
  assign act = {ws_gen, frame_start, in_valid, in_left, in_right, out_ready,
                tx_left, tx_right, overrun, underrun, drop_count};

  always @(posedge sclk) begin
    if (rst) begin
      m_t = 0; m_iv = 0; m_ov = 0; m_un = 0; m_dc = 0;
      m_il = '0; m_ir = '0; m_tl = '0; m_tr = '0;
      m_q.delete();
    end else begin
      m_f = m_fs();
      m_ev = 0;
      if (err_clr) begin m_ov = 0; m_un = 0; m_dc = 0; end
      if (m_f) begin
        if (m_iv && !in_ready) begin m_ov = 1; m_ev++; end
        m_il = rx_left; m_ir = rx_right; m_iv = 1;
        if (m_q.size() != 0) {m_tl, m_tr} = m_q.pop_front();
        else if (out_valid) begin m_tl = out_left; m_tr = out_right; end
        else begin m_un = 1; m_ev++; end
      end else begin
        if (m_iv && in_ready) m_iv = 0;
        if (out_valid && m_q.size() == 0) m_q.push_back({out_left, out_right});
      end
      m_dc = (m_dc + m_ev > 255) ? 255 : m_dc + m_ev;
      m_t++;
    end
  end

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic wait_fs(output bit ok);
    ok = 0;
    for (int k = 0; k < F + 2 && !ok; k++) begin
      if (m_fs()) ok = 1;
      else step();
    end
  endtask

  task automatic test_reset();
    int first = -1;
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({ws_gen, frame_start, in_valid, out_ready, overrun, underrun, drop_count} !== 14'b00010000000000
        || {in_left, in_right, tx_left, tx_right} !== 64'd0) begin
      errors++; $display("FAIL reset_vals act %h exp reset values", act);
    end
    rst = 1'b0;
    in_ready = 1'b1;
    for (int i = 0; i < 70; i++) begin
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL idle cyc %0d act %h exp %h", i, act, exp_vec());
      end
      if (frame_start === 1'b1 && first < 0) first = i;
      if (i <= 32) begin
        checks++;
        if ({overrun, underrun, drop_count} !== 10'd0) begin
          errors++; $display("FAIL idle_flags cyc %0d act %h exp 0", i, {overrun, underrun, drop_count});
        end
      end
      step();
    end
    checks++;
    if (first != 32) begin errors++; $display("FAIL first_fs act %0d exp 32", first); end
  endtask

  task automatic test_echo();
    bit ok;
    wait_fs(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL echo_wait act timeout exp frame_start"); end
    rx_left = 16'h1234; rx_right = 16'hABCD; in_ready = 1'b1; err_clr = 1'b1;
    out_valid = 1'b1; out_left = W'($urandom); out_right = W'($urandom);
    step();
    err_clr = 1'b0; out_valid = 1'b0; rx_left = W'($urandom); rx_right = W'($urandom);
    step();
    out_valid = 1'b1; out_left = 16'h1234; out_right = 16'hABCD;
    step();
    out_valid = 1'b0;
    for (int k = 3; k < F + 1; k++) begin
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL echo cyc %0d act %h exp %h", m_t, act, exp_vec());
      end
      step();
    end
    checks++;
    if ({tx_left, tx_right, overrun, underrun} !== {16'h1234, 16'hABCD, 2'b00}) begin
      errors++; $display("FAIL echo_tx act %h exp 1234abcd flags 0", {tx_left, tx_right, overrun, underrun});
    end
  endtask

  task automatic test_overrun();
    bit ok;
    logic [W-1:0] bl, br;
    out_valid = 1'b1; out_left = 16'h5A5A; out_right = 16'hC3C3;
    step();
    in_ready = 1'b0;
    wait_fs(ok);
    rx_left = W'($urandom); rx_right = W'($urandom);
    step();
    checks++;
    if (act !== exp_vec() || overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_first act %h exp %h", act, exp_vec());
    end
    wait_fs(ok);
    bl = W'($urandom); br = W'($urandom);
    rx_left = bl; rx_right = br;
    step();
    checks++;
    if ({overrun, underrun, drop_count, in_left, in_right} !== {2'b10, 8'd1, bl, br}) begin
      errors++; $display("FAIL overrun act %h exp %h", {overrun, underrun, drop_count, in_left, in_right},
                         {2'b10, 8'd1, bl, br});
    end
    checks++;
    if (!ok || act !== exp_vec()) begin
      errors++; $display("FAIL ovr_model act %h exp %h", act, exp_vec());
    end
  endtask

  task automatic test_underrun();
    bit ok;
    logic [W-1:0] nl, nr;
    in_ready = 1'b1; out_valid = 1'b0; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    wait_fs(ok);
    step();
    checks++;
    if ({tx_left, tx_right, underrun, overrun, drop_count} !== {16'h5A5A, 16'hC3C3, 2'b10, 8'd1}) begin
      errors++; $display("FAIL underrun act %h exp %h", {tx_left, tx_right, underrun, overrun, drop_count},
                         {16'h5A5A, 16'hC3C3, 2'b10, 8'd1});
    end
    wait_fs(ok);
    nl = W'($urandom); nr = W'($urandom);
    out_valid = 1'b1; out_left = nl; out_right = nr;
    step();
    out_valid = 1'b0;
    checks++;
    if ({tx_left, tx_right, drop_count, out_ready} !== {nl, nr, 8'd1, 1'b1}) begin
      errors++; $display("FAIL bypass act %h exp %h", {tx_left, tx_right, drop_count, out_ready},
                         {nl, nr, 8'd1, 1'b1});
    end
    checks++;
    if (!ok || act !== exp_vec()) begin
      errors++; $display("FAIL bypass_model act %h exp %h", act, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [W-1:0] cl, cr;
    in_ready = 1'b0; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    wait_fs(ok);
    cl = W'($urandom); cr = W'($urandom);
    rx_left = cl; rx_right = cr; in_ready = 1'b1;
    step();
    checks++;
    if ({in_valid, in_left, in_right, overrun} !== {1'b1, cl, cr, 1'b0}) begin
      errors++; $display("FAIL b2b act %h exp %h", {in_valid, in_left, in_right, overrun}, {1'b1, cl, cr, 1'b0});
    end
    wait_fs(ok);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if ({underrun, overrun, drop_count} !== {2'b10, 8'd1}) begin
      errors++; $display("FAIL clr_vs_und act %h exp %h", {underrun, overrun, drop_count}, {2'b10, 8'd1});
    end
    checks++;
    if (!ok || act !== exp_vec()) begin
      errors++; $display("FAIL b2b_model act %h exp %h", act, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40 * F; k++) begin
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d act %h exp %h", m_t, act, exp_vec());
      end
      in_ready = ($urandom_range(0, 3) != 0);
      rx_left = W'($urandom); rx_right = W'($urandom);
      err_clr = ($urandom_range(0, 31) == 0);
      if (!(out_valid && m_q.size() != 0)) begin
        out_valid = ($urandom_range(0, 2) != 0);
        out_left = W'($urandom); out_right = W'($urandom);
      end
      step();
    end
    err_clr = 1'b0;
  endtask

  task automatic test_saturate();
    out_valid = 1'b0; in_ready = 1'b1; err_clr = 1'b0;
    for (int k = 0; k < 300 * F; k++) step();
    checks++;
    if (drop_count !== 8'hFF || act !== exp_vec()) begin
      errors++; $display("FAIL saturate act %0d exp 255", drop_count);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    for (int k = 0; k < F + 1 && (m_t % F) != 20; k++) step();
    in_ready = 1'b0; out_valid = 1'b1; out_left = W'($urandom); out_right = W'($urandom);
    rst = 1'b1;
    step();
    checks++;
    if ({ws_gen, frame_start, in_valid, out_ready, overrun, underrun, drop_count} !== 14'b00010000000000
        || {in_left, in_right, tx_left, tx_right} !== 64'd0 || act !== exp_vec()) begin
      errors++; $display("FAIL mid_reset act %h exp reset values", act);
    end
    rst = 1'b0; out_valid = 1'b0;
    while (frame_start !== 1'b1 && n < F + 8) begin
      step();
      n++;
    end
    checks++;
    if (n != 32) begin errors++; $display("FAIL mid_reset_fs act %0d exp 32", n); end
  endtask

  initial begin
    test_reset();
    test_echo();
    test_overrun();
    test_underrun();
    test_back_to_back();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
